// File: rtl/sao_stat_diff_accum.sv
`default_nettype none
// ============================================================================
// Module   : sao_stat_diff_accum
// Brief    : SAO statistics collector - per-lane clipped (org - rec) diffs
//            accumulated per category over one block, emitted via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module sao_stat_diff_accum #(
    parameter int BIT_DEPTH     = 8,
    parameter int DIFF_CLIP_BIT = 4,
    parameter int NUM_PIX       = 4,
    parameter int NUM_CAT       = 5,
    parameter int SUM_BIT       = 16,
    parameter int CNT_BIT       = 12,
    parameter int CAT_W         = (NUM_CAT > 1) ? $clog2(NUM_CAT) : 1
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [NUM_PIX*BIT_DEPTH-1:0] rec,
    input  logic [NUM_PIX*BIT_DEPTH-1:0] org,
    input  logic [NUM_PIX*CAT_W-1:0]     cat,
    input  logic [NUM_PIX-1:0]           pix_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CAT*SUM_BIT-1:0]   out_sum,
    output logic [NUM_CAT*CNT_BIT-1:0]   out_cnt,
    output logic                         err_seq
);

    localparam int DW  = DIFF_CLIP_BIT + 1;
    localparam int NW  = $clog2(NUM_PIX + 1);
    localparam int EW  = SUM_BIT + DW + NUM_PIX;
    localparam int CTW = CNT_BIT + NW;

    localparam logic signed [BIT_DEPTH:0] C_CLIP_HI = (BIT_DEPTH + 1)'(2 ** DIFF_CLIP_BIT);
    localparam logic signed [BIT_DEPTH:0] C_CLIP_LO = -C_CLIP_HI;
    localparam logic signed [DW-1:0]      C_DMAX    = {1'b0, {DIFF_CLIP_BIT{1'b1}}};
    localparam logic signed [DW-1:0]      C_DMIN    = ~C_DMAX + DW'(1);
    localparam logic signed [EW-1:0]      C_SMAX    = {{(EW - SUM_BIT + 1){1'b0}}, {(SUM_BIT - 1){1'b1}}};
    localparam logic signed [EW-1:0]      C_SMIN    = ~C_SMAX;
    localparam logic [CTW-1:0]            C_CMAX    = {{NW{1'b0}}, {CNT_BIT{1'b1}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]                        state_d, state_q;
    logic                              s1_valid_d, s1_valid_q;
    logic                              s1_first_q, s1_last_q;
    logic [NUM_PIX-1:0][DW-1:0]        diff_d, diff_q;
    logic [NUM_PIX*CAT_W-1:0]          cat_q;
    logic [NUM_PIX-1:0]                en_q;
    logic [NUM_CAT-1:0][SUM_BIT-1:0]   sum_d, sum_q;
    logic [NUM_CAT-1:0][CNT_BIT-1:0]   cnt_d, cnt_q;
    logic [NUM_CAT*SUM_BIT-1:0]        out_sum_d, out_sum_q;
    logic [NUM_CAT*CNT_BIT-1:0]        out_cnt_d, out_cnt_q;
    logic                              out_valid_d, out_valid_q;
    logic                              err_seq_d, err_seq_q;
    logic                              w_accept;

    // Lane diff in BIT_DEPTH+1 signed bits, clipped symmetrically to +/-(2^dcb-1)
    for (genvar gi = 0; gi < NUM_PIX; gi++) begin : g_lane
        logic signed [BIT_DEPTH:0] w_d;
        assign w_d = $signed({1'b0, org[gi*BIT_DEPTH +: BIT_DEPTH]})
                   - $signed({1'b0, rec[gi*BIT_DEPTH +: BIT_DEPTH]});
        assign diff_d[gi] = (w_d <= C_CLIP_LO) ? C_DMIN :
                            (w_d >= C_CLIP_HI) ? C_DMAX : w_d[DW-1:0];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            diff_q      <= '0;
            cat_q       <= '0;
            en_q        <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= in_first;
            s1_last_q   <= in_last;
            diff_q      <= diff_d;
            cat_q       <= cat;
            en_q        <= pix_en;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            err_seq_q   <= err_seq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept && in_first) state_d = in_last ? S_FLUSH : S_ACC;
            S_ACC:   if (w_accept && in_last)  state_d = S_FLUSH;
            S_FLUSH: if (s1_valid_q && s1_last_q) state_d = S_OUT;
            S_OUT:   if (out_valid_q && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == S_IDLE) || (state_q == S_ACC);
        w_accept    = in_valid && in_ready;
        // Only block-opening beats are taken in IDLE; stray beats are dropped
        s1_valid_d  = w_accept && ((state_q == S_ACC) || in_first);
        err_seq_d   = err_seq_q || (w_accept && (state_q == S_IDLE) && !in_first);
        out_valid_d = (state_q == S_OUT) && !(out_valid_q && out_ready);
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        if ((state_q == S_OUT) && !out_valid_q) begin
            out_sum_d = sum_q;
            out_cnt_d = cnt_q;
        end
    end

    always_comb begin
        logic signed [EW-1:0] beat_sum, sum_base, sum_tot;
        logic [NW-1:0]        beat_cnt;
        logic [CTW-1:0]       cnt_base, cnt_tot;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        beat_sum = '0;
        sum_base = '0;
        sum_tot  = '0;
        beat_cnt = '0;
        cnt_base = '0;
        cnt_tot  = '0;
        if (s1_valid_q) begin
            for (int k = 0; k < NUM_CAT; k++) begin
                beat_sum = '0;
                beat_cnt = '0;
                for (int i = 0; i < NUM_PIX; i++) begin
                    if (en_q[i] && (cat_q[i*CAT_W +: CAT_W] == CAT_W'(k))) begin
                        beat_sum = beat_sum + EW'($signed(diff_q[i]));
                        beat_cnt = beat_cnt + NW'(1);
                    end
                end
                // A first beat starts the block over instead of adding
                sum_base = s1_first_q ? '0 : EW'($signed(sum_q[k]));
                cnt_base = s1_first_q ? '0 : CTW'(cnt_q[k]);
                sum_tot  = sum_base + beat_sum;
                cnt_tot  = cnt_base + CTW'(beat_cnt);
                if (sum_tot > C_SMAX)      sum_d[k] = C_SMAX[SUM_BIT-1:0];
                else if (sum_tot < C_SMIN) sum_d[k] = C_SMIN[SUM_BIT-1:0];
                else                       sum_d[k] = sum_tot[SUM_BIT-1:0];
                cnt_d[k] = (cnt_tot > C_CMAX) ? C_CMAX[CNT_BIT-1:0] : cnt_tot[CNT_BIT-1:0];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign err_seq   = err_seq_q;

endmodule
`default_nettype wire

// File: tb/tb_sao_stat_diff_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_sao_stat_diff_accum
// Brief    : Directed self-checking bench; second instance uses narrow
//            sum/count widths so saturation is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sao_stat_diff_accum;

    logic        clk = 1'b0;
    logic        arst_n, in_valid, in_first, in_last, out_ready;
    logic [31:0] rec, org;
    logic [11:0] cat;
    logic [3:0]  pix_en;
    wire         in_ready, out_valid, err_seq;
    wire  [79:0] out_sum;
    wire  [59:0] out_cnt;
    wire         in_ready2, out_valid2, err_seq2;
    wire  [39:0] out_sum2;
    wire  [19:0] out_cnt2;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    sao_stat_diff_accum u_dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .rec(rec), .org(org), .cat(cat),
        .pix_en(pix_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cnt(out_cnt), .err_seq(err_seq)
    );

    sao_stat_diff_accum #(.SUM_BIT(8), .CNT_BIT(4)) u_dut_small (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_first(in_first), .in_last(in_last), .rec(rec), .org(org), .cat(cat),
        .pix_en(pix_en), .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_cnt(out_cnt2), .err_seq(err_seq2)
    );

    task automatic drive_beat(input logic f, input logic l, input logic [31:0] o,
                              input logic [31:0] r, input logic [11:0] c, input logic [3:0] e);
        in_valid = 1'b1; in_first = f; in_last = l;
        org = o; rec = r; cat = c; pix_en = e;
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout out_valid=%b required=1", name, out_valid);
        end
    endtask

    task automatic take_output();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        if (out_sum !== 80'd0)  begin bad++; $display("FAIL rst_sum got=%h want=0", out_sum); end
        if (out_cnt !== 60'd0)  begin bad++; $display("FAIL rst_cnt got=%h want=0", out_cnt); end
        if (err_seq !== 1'b0)   begin bad++; $display("FAIL rst_err got=%b want=0", err_seq); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_clip();
        int es[5] = '{-5, 0, 0, 0, 0};
        int ec[5] = '{4, 0, 0, 0, 0};
        // lanes 0..3: +100->15, -255->-15, +10, -16->-15
        drive_beat(1'b1, 1'b1, {8'd100, 8'd110, 8'd0, 8'd200}, {8'd116, 8'd100, 8'd255, 8'd100},
                   12'h000, 4'hF);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL clip_flush_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL clip_early_valid got=%b want=0", out_valid); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL clip_latency got=%b want=1", out_valid); end
        for (int k = 0; k < 5; k++) begin
            total += 3;
            if ($signed(out_sum[k*16 +: 16]) !== es[k]) begin
                bad++; $display("FAIL clip_sum%0d got=%0d want=%0d", k, $signed(out_sum[k*16 +: 16]), es[k]);
            end
            if (out_cnt[k*12 +: 12] !== 12'(ec[k])) begin
                bad++; $display("FAIL clip_cnt%0d got=%0d want=%0d", k, out_cnt[k*12 +: 12], ec[k]);
            end
            if ($signed(out_sum2[k*8 +: 8]) !== es[k]) begin
                bad++; $display("FAIL clip_sum_small%0d got=%0d want=%0d", k, $signed(out_sum2[k*8 +: 8]), es[k]);
            end
        end
        take_output();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL clip_release_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL clip_release_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_multicat();
        int es[5] = '{12, 12, 0, 12, 0};
        int ec[5] = '{4, 4, 0, 4, 0};
        for (int pass = 0; pass < 2; pass++) begin
            // pass 0: lane 2 disabled; pass 1: lane 2 enabled but category 7
            for (int b = 0; b < 4; b++)
                drive_beat(b == 0, b == 3, {4{8'd103}}, {4{8'd100}},
                           (pass == 0) ? {3'd3, 3'd2, 3'd1, 3'd0} : {3'd3, 3'd7, 3'd1, 3'd0},
                           (pass == 0) ? 4'b1011 : 4'b1111);
            wait_out($sformatf("multi%0d", pass));
            for (int k = 0; k < 5; k++) begin
                total += 2;
                if ($signed(out_sum[k*16 +: 16]) !== es[k]) begin
                    bad++; $display("FAIL multi%0d_sum%0d got=%0d want=%0d", pass, k, $signed(out_sum[k*16 +: 16]), es[k]);
                end
                if (out_cnt[k*12 +: 12] !== 12'(ec[k])) begin
                    bad++; $display("FAIL multi%0d_cnt%0d got=%0d want=%0d", pass, k, out_cnt[k*12 +: 12], ec[k]);
                end
            end
            take_output();
        end
    endtask

    task automatic test_backpressure();
        drive_beat(1'b1, 1'b1, {4{8'd105}}, {4{8'd100}}, {3'd1, 3'd1, 3'd0, 3'd0}, 4'hF);
        wait_out("bp");
        for (int c = 0; c < 10; c++) begin
            total += 4;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d got=%b want=1", c, out_valid); end
            if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_ready c%0d got=%b want=0", c, in_ready); end
            if (out_sum[31:0] !== {16'd10, 16'd10}) begin
                bad++; $display("FAIL bp_sum c%0d got=%h want=000a000a", c, out_sum[31:0]);
            end
            if (out_cnt[23:0] !== {12'd2, 12'd2}) begin
                bad++; $display("FAIL bp_cnt c%0d got=%h want=002002", c, out_cnt[23:0]);
            end
            @(posedge clk); #1;
        end
        take_output();
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_done_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_done_ready got=%b want=1", in_ready); end
        if (out_sum[15:0] !== 16'd10) begin bad++; $display("FAIL bp_hold_sum got=%0d want=10", out_sum[15:0]); end
    endtask

    task automatic test_saturation();
        int es[2]  = '{600, -600};
        int es2[2] = '{127, -128};
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 10; b++)
                drive_beat(b == 0, b == 9, (p == 0) ? {4{8'd215}} : {4{8'd0}},
                           (p == 0) ? {4{8'd100}} : {4{8'd200}}, 12'h000, 4'hF);
            wait_out($sformatf("sat%0d", p));
            total += 4;
            if ($signed(out_sum[15:0]) !== es[p]) begin
                bad++; $display("FAIL sat%0d_sum got=%0d want=%0d", p, $signed(out_sum[15:0]), es[p]);
            end
            if (out_cnt[11:0] !== 12'd40) begin
                bad++; $display("FAIL sat%0d_cnt got=%0d want=40", p, out_cnt[11:0]);
            end
            if ($signed(out_sum2[7:0]) !== es2[p]) begin
                bad++; $display("FAIL sat%0d_sum_small got=%0d want=%0d", p, $signed(out_sum2[7:0]), es2[p]);
            end
            if (out_cnt2[3:0] !== 4'd15) begin
                bad++; $display("FAIL sat%0d_cnt_small got=%0d want=15", p, out_cnt2[3:0]);
            end
            take_output();
        end
    endtask

    task automatic test_sequencing();
        drive_beat(1'b0, 1'b0, {4{8'd105}}, {4{8'd100}}, 12'h000, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        total += 4;
        if (err_seq !== 1'b1)   begin bad++; $display("FAIL seq_err got=%b want=1", err_seq); end
        if (err_seq2 !== 1'b1)  begin bad++; $display("FAIL seq_err_small got=%b want=1", err_seq2); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL seq_idle_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL seq_no_out got=%b want=0", out_valid); end
        drive_beat(1'b1, 1'b0, {4{8'd105}}, {4{8'd100}}, 12'h000, 4'hF);
        drive_beat(1'b0, 1'b0, {4{8'd105}}, {4{8'd100}}, 12'h000, 4'hF);
        drive_beat(1'b1, 1'b0, {4{8'd102}}, {4{8'd100}}, {4{3'd1}}, 4'hF);
        drive_beat(1'b0, 1'b1, {4{8'd101}}, {4{8'd100}}, {4{3'd1}}, 4'hF);
        wait_out("seq");
        total += 3;
        if (out_sum[31:0] !== {16'd12, 16'd0}) begin
            bad++; $display("FAIL seq_restart_sum got=%h want=000c0000", out_sum[31:0]);
        end
        if (out_cnt[23:0] !== {12'd8, 12'd0}) begin
            bad++; $display("FAIL seq_restart_cnt got=%h want=008000", out_cnt[23:0]);
        end
        if (err_seq !== 1'b1) begin bad++; $display("FAIL seq_err_sticky got=%b want=1", err_seq); end
        take_output();
    endtask

    task automatic test_reset_mid();
        drive_beat(1'b1, 1'b0, {4{8'd105}}, {4{8'd100}}, 12'h000, 4'hF);
        drive_beat(1'b0, 1'b0, {4{8'd105}}, {4{8'd100}}, 12'h000, 4'hF);
        #2 arst_n = 1'b0;
        #1;
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
        if (out_sum !== 80'd0)  begin bad++; $display("FAIL mid_rst_sum got=%h want=0", out_sum); end
        if (out_cnt !== 60'd0)  begin bad++; $display("FAIL mid_rst_cnt got=%h want=0", out_cnt); end
        if (err_seq !== 1'b0)   begin bad++; $display("FAIL mid_rst_err got=%b want=0", err_seq); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL mid_rst_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        drive_beat(1'b1, 1'b1, {4{8'd103}}, {4{8'd100}}, {4{3'd2}}, 4'hF);
        wait_out("mid");
        total += 2;
        if (out_sum !== {16'd0, 16'd0, 16'd12, 16'd0, 16'd0}) begin
            bad++; $display("FAIL mid_clean_sum got=%h want=c at cat2 only", out_sum);
        end
        if (out_cnt !== {12'd0, 12'd0, 12'd4, 12'd0, 12'd0}) begin
            bad++; $display("FAIL mid_clean_cnt got=%h want=4 at cat2 only", out_cnt);
        end
        take_output();
    endtask

    initial begin
        arst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        rec = '0; org = '0; cat = '0; pix_en = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        arst_n = 1'b1;
        @(posedge clk); #1;
        test_clip();
        test_multicat();
        test_backpressure();
        test_saturation();
        test_sequencing();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
